// File: rtl/pc_fetch_pkg.sv
// Shared constants for the program-counter / fetch sequencer.
package pc_fetch_pkg;

    localparam int PC_BITS = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_ADVANCE = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

endpackage

// File: rtl/mux_2x1_nbits.sv
// Generic n-bit two-input multiplexer: xout = sel ? xin_1 : xin_0.
module mux_2x1_nbits #(
    parameter int bits = 4
) (
    input  logic            sel,
    input  logic [bits-1:0] xin_0,
    input  logic [bits-1:0] xin_1,
    output logic [bits-1:0] xout
);

    assign xout = sel ? xin_1 : xin_0;

endmodule

// File: rtl/pc_fetch_seq.sv
// PC register and req/ack instruction-fetch sequencer feeding the decoder.
// Jumps and halts seen mid-fetch are held pending and applied in ADVANCE.
module pc_fetch_seq
    import pc_fetch_pkg::*;
#(
    parameter int              bits     = PC_BITS,
    parameter logic [bits-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic            jmp_en,
    input  logic [bits-1:0] jmp_addr,
    output logic            mem_req,
    output logic [bits-1:0] mem_addr,
    input  logic            mem_ack,
    output logic            instr_valid,
    output logic [bits-1:0] pc,
    output logic [bits-1:0] pc_seq,
    output logic            busy
);

    localparam logic [bits-1:0] PC_ONE = {{(bits-1){1'b0}}, 1'b1};

    logic [1:0]      state_q,     state_d;
    logic [bits-1:0] pc_q,        pc_d;
    logic            jmp_pend_q,  jmp_pend_d;
    logic [bits-1:0] jmp_tgt_q,   jmp_tgt_d;
    logic            halt_pend_q, halt_pend_d;

    logic            mux_sel;
    logic [bits-1:0] mux_jmp;
    logic [bits-1:0] mux_out;

    assign pc_seq = pc_q + PC_ONE;

    // A jump arriving in the ADVANCE cycle itself beats the pending target.
    assign mux_sel = jmp_en | jmp_pend_q;
    assign mux_jmp = jmp_en ? jmp_addr : jmp_tgt_q;

    mux_2x1_nbits #(.bits(bits)) u_next_pc_mux (
        .sel   (mux_sel),
        .xin_0 (pc_seq),
        .xin_1 (mux_jmp),
        .xout  (mux_out)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        jmp_pend_d  = jmp_pend_q;
        jmp_tgt_d   = jmp_tgt_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    if (jmp_en) pc_d = jmp_addr;
                    if (start)  state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (jmp_en) begin
                    jmp_pend_d = 1'b1;
                    jmp_tgt_d  = jmp_addr;
                end
                if (halt)    halt_pend_d = 1'b1;
                if (mem_ack) state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                pc_d       = mux_out;
                jmp_pend_d = 1'b0;
                state_d    = (halt | halt_pend_q) ? ST_HALTED : ST_FETCH;
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            jmp_pend_q  <= 1'b0;
            jmp_tgt_q   <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            jmp_pend_q  <= jmp_pend_d;
            jmp_tgt_q   <= jmp_tgt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign mem_req     = (state_q == ST_FETCH);
    assign mem_addr    = mem_req ? pc_q : '0;
    assign instr_valid = (state_q == ST_ADVANCE);
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_ADVANCE);
    assign pc          = pc_q;

endmodule
